// File: rtl/sseg_pkg.sv
// Shared constants, scan state type and hex font for the seven-segment scan driver.
package sseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sseg_scan_driver_tick_detect.sv
// Rising-edge detector for the divided scan clock, sampled as a level on clk.
module tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    output logic tick
);

    logic sclk_d;
    logic sclk_q;

    always_comb begin
        sclk_d = sclk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk_d;
        end
    end

    assign tick = sclk & ~sclk_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking and per-frame snapshot.
//   state | meaning
//   BLANK | all anodes off, counting out the anti-ghost interval
//   DRIVE | selected digit driven from the shadow registers
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int BLANK_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic [15:0] value,
    input  logic [3:0]  dig_en,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [BLANK_W-1:0] BLANK_LAST =
        BLANK_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    logic               tick;
    scan_state_t        state_d, state_q;
    logic [BLANK_W-1:0] cnt_d, cnt_q;
    logic [1:0]         idx_d, idx_q;
    logic [15:0]        sh_value_d, sh_value_q;
    logic [3:0]         sh_en_d, sh_en_q;
    logic [3:0]         sh_dp_d, sh_dp_q;
    logic               sh_lz_d, sh_lz_q;
    logic               frame_done_d, frame_done_q;
    logic [3:0]         an_d, an_q;
    logic [6:0]         seg_d, seg_q;
    logic               dp_d, dp_q;
    logic [3:0]         nib;
    logic               lz_hit;

    tick_detect u_tick (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sh_value_d   = sh_value_q;
        sh_en_d      = sh_en_q;
        sh_dp_d      = sh_dp_q;
        sh_lz_d      = sh_lz_q;
        frame_done_d = 1'b0;
        if (tick) begin
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            if (idx_q == 2'd3) begin
                sh_value_d   = value;
                sh_en_d      = dig_en;
                sh_dp_d      = dp_in;
                sh_lz_d      = blank_lz;
                frame_done_d = 1'b1;
            end
        end else if (state_q == BLANK) begin
            if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                state_d = DRIVE;
            end else begin
                cnt_d = cnt_q + BLANK_W'(1);
            end
        end
    end

    // Outputs are decoded from next-state values so they change on the same edge as idx/state.
    always_comb begin
        nib    = sh_value_d[{idx_d, 2'b00} +: 4];
        lz_hit = sh_lz_d && (idx_d != 2'd0) && ((sh_value_d >> {idx_d, 2'b00}) == 16'h0000);
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        if (state_d == DRIVE && sh_en_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
            dp_d        = ~sh_dp_d[idx_d];
            if (!lz_hit) begin
                seg_d = hex_to_seg(nib);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd3;
            sh_value_q   <= '0;
            sh_en_q      <= '0;
            sh_dp_q      <= '0;
            sh_lz_q      <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_value_q   <= sh_value_d;
            sh_en_q      <= sh_en_d;
            sh_dp_q      <= sh_dp_d;
            sh_lz_q      <= sh_lz_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two instances (4-cycle blank and no blank) against a per-cycle reference model.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic [15:0] value;
    logic [3:0]  dig_en;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b;

    sseg_scan_driver #(.BLANK_CYCLES(4), .BLANK_W(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .value(value), .dig_en(dig_en),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .an(an_a),
        .frame_done(fd_a)
    );

    sseg_scan_driver #(.BLANK_CYCLES(0), .BLANK_W(8)) dut0 (
        .clk(clk), .rst(rst), .sclk(sclk), .value(value), .dig_en(dig_en),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .an(an_b),
        .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which digit is selected, how long since it was selected, and the frame snapshot.
    logic [1:0]  m_idx;
    int          m_since;
    bit          m_fresh;
    bit          m_prev;
    bit          m_fd;
    logic [15:0] m_val;
    logic [3:0]  m_en;
    logic [3:0]  m_dp;
    bit          m_lz;

    logic        sclk_lvl;
    int          ph_cnt;
    int          half;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic model_reset();
        m_idx = 2'd3; m_since = 0; m_fresh = 1; m_prev = 0; m_fd = 0;
        m_val = '0; m_en = '0; m_dp = '0; m_lz = 0;
        sclk_lvl = 1'b0; ph_cnt = 0;
    endtask

    task automatic expect_out(input int blank, output logic [3:0] e_an,
                              output logic [6:0] e_seg, output logic e_dp);
        logic [15:0] upper;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        upper = m_val >> (4 * m_idx);
        if (!m_fresh && m_since >= blank && m_en[m_idx]) begin
            e_an = 4'hF ^ (4'b1 << m_idx);
            e_dp = ~m_dp[m_idx];
            if (!(m_lz && m_idx != 2'd0 && upper == 16'h0000))
                e_seg = font(upper[3:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ea; logic [6:0] es; logic ed;
        expect_out(4, ea, es, ed);
        n_cmp++;
        assert ({an_a, seg_a, dp_a, fd_a} === {ea, es, ed, m_fd}) else begin
            n_bad++;
            $error("FAIL %s blank4 @%0t: observed an=%b seg=%b dp=%b fd=%b expected an=%b seg=%b dp=%b fd=%b",
                   tag, $time, an_a, seg_a, dp_a, fd_a, ea, es, ed, m_fd);
        end
        expect_out(0, ea, es, ed);
        n_cmp++;
        assert ({an_b, seg_b, dp_b, fd_b} === {ea, es, ed, m_fd}) else begin
            n_bad++;
            $error("FAIL %s blank0 @%0t: observed an=%b seg=%b dp=%b fd=%b expected an=%b seg=%b dp=%b fd=%b",
                   tag, $time, an_b, seg_b, dp_b, fd_b, ea, es, ed, m_fd);
        end
    endtask

    // One clk cycle with sclk held at level s, then model update and check.
    task automatic step(input logic s, input string tag);
        bit tk;
        sclk = s;
        @(posedge clk);
        tk = s && !m_prev;
        m_prev = s; m_fresh = 0; m_fd = 0;
        if (tk) begin
            m_idx = m_idx + 2'd1;
            m_since = 0;
            if (m_idx == 2'd0) begin
                m_val = value; m_en = dig_en; m_dp = dp_in; m_lz = blank_lz; m_fd = 1;
            end
        end else if (m_since < 100000) begin
            m_since++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic advance(input string tag);
        if (ph_cnt >= half) begin
            sclk_lvl = ~sclk_lvl;
            ph_cnt = 0;
        end
        ph_cnt++;
        step(sclk_lvl, tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) advance(tag);
    endtask

    // Scan until the 4-cycle-blank instance drives digit d, bounded.
    task automatic wait_digit(input int d, input string tag);
        logic [3:0] tgt;
        int n;
        tgt = 4'hF ^ (4'b1 << d);
        n = 0;
        while (an_a !== tgt && n < 400) begin
            advance(tag);
            n++;
        end
        chk({tag, "_reached"}, 16'(n < 400), 16'd1);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; value = '0; dig_en = '0; dp_in = '0; blank_lz = 1'b0;
        half = 8;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_an", 16'(an_a), 16'h000F);
        chk("rst_seg", 16'(seg_a), 16'h007F);
        chk("rst_dp_fd", 16'({dp_a, fd_a}), 16'h0002);
        chk("rst_an0", 16'(an_b), 16'h000F);
        rst = 1'b0;
        model_reset();

        // Test 1: basic scan of 12AF
        value = 16'h12AF; dig_en = 4'hF; dp_in = 4'h0; blank_lz = 1'b0;
        run(80, "t1_fill");
        wait_digit(0, "t1_d0"); chk("t1_seg0", 16'(seg_a), 16'h000E);
        wait_digit(1, "t1_d1"); chk("t1_seg1", 16'(seg_a), 16'h0008);
        wait_digit(2, "t1_d2"); chk("t1_seg2", 16'(seg_a), 16'h0024);
        wait_digit(3, "t1_d3"); chk("t1_seg3", 16'(seg_a), 16'h0079);

        // Test 2: leading-zero suppression on and off
        value = 16'h0005; blank_lz = 1'b1;
        run(160, "t2_lz");
        wait_digit(0, "t2_d0"); chk("t2_seg0", 16'(seg_a), 16'h0012);
        blank_lz = 1'b0;
        run(160, "t2_nolz");
        wait_digit(3, "t2_d3"); chk("t2_seg3", 16'(seg_a), 16'h0040);

        // Test 3: mid-frame value change must not tear
        value = 16'h1111;
        run(160, "t3_fill");
        wait_digit(1, "t3_d1");
        value = 16'h2222;
        wait_digit(2, "t3_d2"); chk("t3_seg2_old", 16'(seg_a), 16'h0079);
        wait_digit(3, "t3_d3"); chk("t3_seg3_old", 16'(seg_a), 16'h0079);
        wait_digit(0, "t3_d0"); chk("t3_seg0_new", 16'(seg_a), 16'h0024);

        // Test 4: stuck sclk
        wait_digit(1, "t4_d1");
        for (int i = 0; i < 1000; i++) step(1'b0, "t4_stuck");
        sclk_lvl = 1'b0; ph_cnt = 0;

        // Test 5: async reset mid-DRIVE on digit 2
        wait_digit(2, "t5_d2");
        #3;
        rst = 1'b1; sclk = 1'b0;
        #1;
        chk("t5_an", 16'(an_a), 16'h000F);
        chk("t5_seg", 16'(seg_a), 16'h007F);
        chk("t5_an0", 16'(an_b), 16'h000F);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        begin
            int n;
            n = 0;
            while (fd_a !== 1'b1 && n < 100) begin
                advance("t5_wait_fd");
                n++;
            end
            chk("t5_fd_seen", 16'(n < 100), 16'd1);
            chk("t5_an0_d0", 16'(an_b), 16'h000E);
        end

        // Test 6: sparse enables and a single decimal point
        value = 16'h4321; dig_en = 4'b0101; dp_in = 4'b0001; blank_lz = 1'b0;
        run(200, "t6");
        wait_digit(0, "t6_d0"); chk("t6_dp0", 16'(dp_a), 16'h0000);

        // Randomized scan with changing rates and data
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dig_en   = 4'($urandom);
                dp_in    = 4'($urandom);
                blank_lz = 1'($urandom);
            end
            if ($urandom_range(0, 149) == 0) half = $urandom_range(1, 6);
            advance("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
